// File: rtl/frame_sum_pkg.sv
// Shared stream definitions: flag bit positions and the frame_sum state encoding.
package frame_sum_pkg;
  localparam int MF_A = 3;
  localparam int MF_F = 2;
  localparam int MF_L = 1;
  localparam int MF_V = 0;
  localparam int SF_ABT = 1;
  localparam int SF_BSY = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_HOLD,
    S_DRAIN
  } state_t;
endpackage

// File: rtl/stream_out_reg.sv
// Output holding register for a stream stage: captures one result, keeps it stable
// while downstream is busy, and drops it on transfer or on a downstream abort.
module stream_out_reg
  import frame_sum_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic          load_trunc,
  input  logic [1:0]    dc_sflags,
  output logic [DW-1:0] data,
  output logic [3:0]    mflags,
  output logic          xfer
);
  assign xfer = mflags[MF_V] & ~dc_sflags[SF_BSY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data   <= '0;
      mflags <= '0;
    end else if (dc_sflags[SF_ABT]) begin
      data   <= '0;
      mflags <= '0;
    end else if (load) begin
      data   <= load_data;
      mflags <= {load_trunc, 3'b111};
    end else if (xfer) begin
      mflags <= '0;
    end
  end
endmodule

// File: rtl/frame_sum.sv
// Accumulates signed samples of each F..L frame and emits {sum, count} once per frame,
// truncating frames at MAXLEN samples and dropping the remainder of such frames.
module frame_sum
  import frame_sum_pkg::*;
#(
  parameter int W      = 16,
  parameter int CW     = 8,
  parameter int MAXLEN = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [W-1:0]    uc_d0,
  input  logic [3:0]      uc_mflags,
  output logic [1:0]      cu_sflags,
  output logic [W+CW-1:0] cd_d0,
  output logic [CW-1:0]   cd_d1,
  output logic [3:0]      cd_mflags,
  input  logic [1:0]      dc_sflags,
  output logic            err
);
  localparam int SW = W + CW;

  // Handshake: a beat moves when the sender's V is high and the receiver's bsy is low
  // on the same clock edge; V/data are held by the sender until that happens.
  state_t          state;
  logic [SW-1:0]   acc;
  logic [CW-1:0]   cnt;
  logic            tr;
  logic [SW-1:0]   sx;
  logic [SW-1:0]   sum_nxt;
  logic [CW-1:0]   cnt_nxt;
  logic            in_xfer;
  logic            in_abort;
  logic            start;
  logic            add;
  logic            close;
  logic            load;
  logic            out_xfer;
  logic            dn_abt;
  logic [SW+CW-1:0] out_data;

  assign dn_abt    = dc_sflags[SF_ABT];
  assign cu_sflags = {dc_sflags[SF_ABT], state == S_HOLD};
  assign in_xfer   = uc_mflags[MF_V] & (state != S_HOLD);
  assign in_abort  = in_xfer & uc_mflags[MF_A];

  always_comb begin
    sx      = {{CW{uc_d0[W-1]}}, uc_d0};
    start   = in_xfer & ~uc_mflags[MF_A] & uc_mflags[MF_F];
    add     = in_xfer & ~uc_mflags[MF_A] & ~uc_mflags[MF_F] & (state == S_ACC);
    sum_nxt = start ? sx : acc + sx;
    cnt_nxt = start ? CW'(1) : cnt + CW'(1);
    // A frame closes on L or when this sample is the MAXLEN-th one.
    close   = (start | add) & (uc_mflags[MF_L] | (cnt_nxt == CW'(MAXLEN)));
    load    = close & ~dn_abt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      acc   <= '0;
      cnt   <= '0;
      tr    <= 1'b0;
      err   <= 1'b0;
    end else if (dn_abt) begin
      state <= S_IDLE;
      acc   <= '0;
      cnt   <= '0;
      tr    <= 1'b0;
    end else if (in_abort) begin
      state <= S_IDLE;
      acc   <= '0;
      cnt   <= '0;
      tr    <= 1'b0;
    end else if (start | add) begin
      acc   <= sum_nxt;
      cnt   <= cnt_nxt;
      tr    <= close & ~uc_mflags[MF_L];
      state <= close ? S_HOLD : S_ACC;
      if (start && state == S_ACC) err <= 1'b1;
    end else begin
      case (state)
        S_IDLE:  if (in_xfer) err <= 1'b1;
        S_HOLD:  if (out_xfer) state <= tr ? S_DRAIN : S_IDLE;
        S_DRAIN: if (in_xfer && uc_mflags[MF_L]) state <= S_IDLE;
        default: state <= state;
      endcase
    end
  end

  stream_out_reg #(.DW(SW + CW)) u_out (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_data  ({sum_nxt, cnt_nxt}),
    .load_trunc (~uc_mflags[MF_L]),
    .dc_sflags  (dc_sflags),
    .data       (out_data),
    .mflags     (cd_mflags),
    .xfer       (out_xfer)
  );

  assign cd_d0 = out_data[SW+CW-1:CW];
  assign cd_d1 = out_data[CW-1:0];
endmodule

// File: tb/tb_frame_sum.sv
// Directed bench for frame_sum (MAXLEN = 4): frame sums, truncation, protocol errors,
// downstream abort/backpressure and asynchronous reset.
module tb_frame_sum;
  logic        clk;
  logic        rst_n;
  logic [15:0] uc_d0;
  logic [3:0]  uc_mflags;
  logic [1:0]  cu_sflags;
  logic [23:0] cd_d0;
  logic [7:0]  cd_d1;
  logic [3:0]  cd_mflags;
  logic [1:0]  dc_sflags;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [35:0] exp_q[$];
  logic        done;

  frame_sum #(.W(16), .CW(8), .MAXLEN(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .uc_d0     (uc_d0),
    .uc_mflags (uc_mflags),
    .cu_sflags (cu_sflags),
    .cd_d0     (cd_d0),
    .cd_d1     (cd_d1),
    .cd_mflags (cd_mflags),
    .dc_sflags (dc_sflags),
    .err       (err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    rst_n = 1'b0;
    uc_d0 = '0;
    uc_mflags = '0;
    dc_sflags = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // driver: present one sample and hold it until accepted; returns at posedge+1
  task automatic send(input logic [15:0] d, input logic [3:0] f);
    int waited;
    waited = 0;
    uc_d0 = d;
    uc_mflags = f;
    @(negedge clk);
    while (cu_sflags[0] && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 100) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: upstream bsy still %b after %0d cycles, required 0", cu_sflags[0], waited);
    end
    @(posedge clk);
    #1;
    uc_mflags = 4'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if ({cd_d0, cd_d1} !== 32'h0) begin n_bad++; $display("FAIL reset_data got=%h exp=0", {cd_d0, cd_d1}); end
    n_cmp++; if (cd_mflags !== 4'b0) begin n_bad++; $display("FAIL reset_mflags got=%b exp=0000", cd_mflags); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", err); end
    n_cmp++; if (cu_sflags !== 2'b00) begin n_bad++; $display("FAIL reset_sflags got=%b exp=00", cu_sflags); end
  endtask

  task automatic test_basic_frame();
    send(16'd3, 4'b0101);
    send(16'd4, 4'b0001);
    send(16'd5, 4'b0001);
    send(16'd6, 4'b0011);
    n_cmp++; if (cd_d0 !== 24'd18) begin n_bad++; $display("FAIL basic_sum got=%0d exp=18", cd_d0); end
    n_cmp++; if (cd_d1 !== 8'd4) begin n_bad++; $display("FAIL basic_cnt got=%0d exp=4", cd_d1); end
    n_cmp++; if (cd_mflags !== 4'b0111) begin n_bad++; $display("FAIL basic_mflags got=%b exp=0111", cd_mflags); end
    n_cmp++; if (cu_sflags !== 2'b01) begin n_bad++; $display("FAIL basic_hold_bsy got=%b exp=01", cu_sflags); end
    @(posedge clk); #1;
    n_cmp++; if (cd_mflags !== 4'b0) begin n_bad++; $display("FAIL basic_after_xfer got=%b exp=0000", cd_mflags); end
    n_cmp++; if (cu_sflags !== 2'b00) begin n_bad++; $display("FAIL basic_idle_bsy got=%b exp=00", cu_sflags); end
  endtask

  task automatic test_single();
    send(16'h8000, 4'b0111);
    n_cmp++; if (cd_d0 !== 24'hFF8000) begin n_bad++; $display("FAIL single_sum got=%h exp=ff8000", cd_d0); end
    n_cmp++; if (cd_d1 !== 8'd1) begin n_bad++; $display("FAIL single_cnt got=%0d exp=1", cd_d1); end
    n_cmp++; if (cd_mflags !== 4'b0111) begin n_bad++; $display("FAIL single_mflags got=%b exp=0111", cd_mflags); end
    @(posedge clk); #1;
  endtask

  task automatic test_truncate();
    send(16'd1, 4'b0101);
    repeat (3) send(16'd1, 4'b0001);
    n_cmp++; if (cd_d0 !== 24'd4) begin n_bad++; $display("FAIL trunc_sum got=%0d exp=4", cd_d0); end
    n_cmp++; if (cd_d1 !== 8'd4) begin n_bad++; $display("FAIL trunc_cnt got=%0d exp=4", cd_d1); end
    n_cmp++; if (cd_mflags !== 4'b1111) begin n_bad++; $display("FAIL trunc_mflags got=%b exp=1111", cd_mflags); end
    @(posedge clk); #1;
    send(16'd1, 4'b0001);
    send(16'd1, 4'b0011);
    n_cmp++; if (cd_mflags !== 4'b0) begin n_bad++; $display("FAIL trunc_drain_output got=%b exp=0000", cd_mflags); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL trunc_drain_err got=%b exp=0", err); end
    send(16'd2, 4'b0101);
    send(16'd5, 4'b0011);
    n_cmp++; if ({cd_d0, cd_d1, cd_mflags} !== {24'd7, 8'd2, 4'b0111}) begin
      n_bad++; $display("FAIL trunc_next_frame got=%h exp=%h", {cd_d0, cd_d1, cd_mflags}, {24'd7, 8'd2, 4'b0111});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_protocol_errors();
    do_reset();
    send(16'd7, 4'b0001);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_no_first got=%b exp=1", err); end
    n_cmp++; if (cd_mflags !== 4'b0) begin n_bad++; $display("FAIL err_no_first_out got=%b exp=0000", cd_mflags); end
    do_reset();
    send(16'd10, 4'b0101);
    send(16'd20, 4'b0001);
    send(16'd100, 4'b0101);
    send(16'd1, 4'b0011);
    n_cmp++; if ({cd_d0, cd_d1} !== {24'd101, 8'd2}) begin n_bad++; $display("FAIL err_restart got=%h exp=%h", {cd_d0, cd_d1}, {24'd101, 8'd2}); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_restart_flag got=%b exp=1", err); end
    @(posedge clk); #1;
    do_reset();
    send(16'd5, 4'b0101);
    send(16'd6, 4'b0001);
    send(16'd7, 4'b1001);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (cd_mflags !== 4'b0) begin n_bad++; $display("FAIL abort_no_output got=%b exp=0000", cd_mflags); end
    send(16'hFFFD, 4'b0111);
    n_cmp++; if ({cd_d0, cd_d1} !== {24'hFFFFFD, 8'd1}) begin n_bad++; $display("FAIL abort_next_frame got=%h exp=%h", {cd_d0, cd_d1}, {24'hFFFFFD, 8'd1}); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL abort_err got=%b exp=0", err); end
    @(posedge clk); #1;
  endtask

  task automatic test_dn_abort();
    dc_sflags = 2'b01;
    send(16'd4, 4'b0101);
    send(16'd8, 4'b0011);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if ({cd_d0, cd_mflags} !== {24'd12, 4'b0111}) begin n_bad++; $display("FAIL dnabt_held got=%h exp=%h", {cd_d0, cd_mflags}, {24'd12, 4'b0111}); end
    n_cmp++; if (cu_sflags !== 2'b01) begin n_bad++; $display("FAIL dnabt_hold_bsy got=%b exp=01", cu_sflags); end
    dc_sflags = 2'b11;
    #1;
    n_cmp++; if (cu_sflags[1] !== 1'b1) begin n_bad++; $display("FAIL dnabt_passthru got=%b exp=1", cu_sflags[1]); end
    @(posedge clk); #1;
    n_cmp++; if (cd_mflags !== 4'b0) begin n_bad++; $display("FAIL dnabt_v_fall got=%b exp=0000", cd_mflags); end
    n_cmp++; if (cu_sflags !== 2'b10) begin n_bad++; $display("FAIL dnabt_idle got=%b exp=10", cu_sflags); end
    dc_sflags = 2'b00;
    send(16'd9, 4'b0111);
    n_cmp++; if ({cd_d0, cd_d1} !== {24'd9, 8'd1}) begin n_bad++; $display("FAIL dnabt_next got=%h exp=%h", {cd_d0, cd_d1}, {24'd9, 8'd1}); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    dc_sflags = 2'b01;
    send(16'd20, 4'b0101);
    send(16'd30, 4'b0011);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({cd_d0, cd_d1, cd_mflags} !== 36'h0) begin n_bad++; $display("FAIL rst_async_out got=%h exp=0", {cd_d0, cd_d1, cd_mflags}); end
    n_cmp++; if (cu_sflags !== 2'b00) begin n_bad++; $display("FAIL rst_async_bsy got=%b exp=00", cu_sflags); end
    dc_sflags = 2'b00;
    @(posedge clk); #1 rst_n = 1'b1;
    send(16'd20, 4'b0101);
    #2 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    send(16'd5, 4'b0111);
    n_cmp++; if ({cd_d0, cd_d1} !== {24'd5, 8'd1}) begin n_bad++; $display("FAIL rst_partial_lost got=%h exp=%h", {cd_d0, cd_d1}, {24'd5, 8'd1}); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err got=%b exp=0", err); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int received;
    received = 0;
    done = 1'b0;
    fork
      begin : driver
        for (int k = 0; k < 50; k++) begin
          int len;
          int sum;
          logic signed [15:0] s;
          len = (k % 4) + 1;
          sum = 0;
          for (int i = 0; i < len; i++) begin
            s = 16'(k * 1237 + i * 4099 - 30000);
            sum += int'(s);
          end
          exp_q.push_back({24'(sum), 8'(len), 4'b0111});
          for (int i = 0; i < len; i++) begin
            s = 16'(k * 1237 + i * 4099 - 30000);
            send(s, {1'b0, (i == 0), (i == len - 1), 1'b1});
          end
        end
        for (int t = 0; t < 500 && exp_q.size() != 0; t++) @(posedge clk);
        #1;
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL b2b_drain_timeout: %0d frames outstanding, required 0", exp_q.size()); end
        n_cmp++; if (received != 50) begin n_bad++; $display("FAIL b2b_frame_count got=%0d exp=50", received); end
        done = 1'b1;
      end
      begin : pattern
        int phase;
        phase = 0;
        while (!done) begin
          @(posedge clk); #1;
          dc_sflags = (phase < 10) ? 2'b01 : 2'b00;
          phase = (phase == 11) ? 0 : phase + 1;
        end
        dc_sflags = 2'b00;
      end
      begin : monitor
        logic [35:0] got;
        logic [35:0] prev;
        logic [35:0] exp;
        logic        prev_hold;
        prev_hold = 1'b0;
        prev = '0;
        while (!done) begin
          @(negedge clk);
          got = {cd_d0, cd_d1, cd_mflags};
          if (cd_mflags[0]) begin
            n_cmp++; if (cu_sflags[0] !== 1'b1) begin n_bad++; $display("FAIL b2b_up_bsy got=%b exp=1", cu_sflags[0]); end
            if (prev_hold) begin
              n_cmp++; if (got !== prev) begin n_bad++; $display("FAIL b2b_stable got=%h exp=%h", got, prev); end
            end
            if (!dc_sflags[0]) begin
              received++;
              n_cmp++;
              if (exp_q.size() == 0) begin
                n_bad++; $display("FAIL b2b_extra_frame got=%h exp=none", got);
              end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin n_bad++; $display("FAIL b2b_frame got=%h exp=%h", got, exp); end
              end
            end
          end
          prev_hold = cd_mflags[0] & dc_sflags[0];
          prev = got;
        end
      end
    join
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL b2b_err got=%b exp=0", err); end
  endtask

  initial begin
    done = 1'b0;
    test_reset();
    test_basic_frame();
    test_single();
    test_truncate();
    test_protocol_errors();
    do_reset();
    test_dn_abort();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
